// File: rtl/fc_argmax.sv
// fc_argmax: streaming argmax over a score vector delivered as Depth beats
// of NumLanes signed scores. Produces the winning class index and score one
// cycle after the last beat, held under a valid/ready handshake.

// Two-input compare cell: forwards b only when strictly greater, so ties
// keep a (the lower class index by construction of the chain).
module fc_argmax_cmp #(
  parameter int BitSize = 8,
  parameter int IdxW    = 3
) (
  input  logic [BitSize-1:0] a_val,
  input  logic [IdxW-1:0]    a_idx,
  input  logic [BitSize-1:0] b_val,
  input  logic [IdxW-1:0]    b_idx,
  output logic [BitSize-1:0] y_val,
  output logic [IdxW-1:0]    y_idx
);
  // signed strict compare, ties resolve to a
  always_comb begin
    y_val = a_val;
    y_idx = a_idx;
    if ($signed(b_val) > $signed(a_val)) begin
      y_val = b_val;
      y_idx = b_idx;
    end
  end
endmodule

module fc_argmax #(
  parameter int BitSize  = 8,
  parameter int NumLanes = 4,
  parameter int Depth    = 2
) (
  input  logic                             clk,
  input  logic                             res_n,
  input  logic                             in_valid,
  input  logic                             in_done,
  input  logic [NumLanes-1:0][BitSize-1:0] in_data,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [((NumLanes*Depth > 1) ? $clog2(NumLanes*Depth) : 1)-1:0] out_class,
  output logic [BitSize-1:0]               out_max,
  output logic                             out_overflow,
  output logic                             busy
);
  localparam int IdxW = (NumLanes*Depth > 1) ? $clog2(NumLanes*Depth) : 1;
  localparam int CntW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [CntW-1:0]                  beat_cnt;
  logic [BitSize-1:0]               run_max;
  logic [IdxW-1:0]                  run_idx;
  logic [IdxW-1:0]                  base_idx;
  logic [NumLanes-1:0][BitSize-1:0] ch_val;
  logic [NumLanes-1:0][IdxW-1:0]    ch_idx;
  logic [BitSize-1:0]               win_val;
  logic [IdxW-1:0]                  win_idx;
  logic                             last;
  logic                             load_out;

  assign base_idx = IdxW'(beat_cnt) * IdxW'(NumLanes);
  assign last     = (beat_cnt == CntW'(Depth-1));
  assign load_out = in_valid && last && (!out_valid || out_ready);
  assign busy     = (beat_cnt != '0);

  // lane-max reduction as a linear chain of compare cells, lane 0 first
  assign ch_val[0] = in_data[0];
  assign ch_idx[0] = base_idx;
  for (genvar l = 1; l < NumLanes; l++) begin : g_lane
    fc_argmax_cmp #(.BitSize(BitSize), .IdxW(IdxW)) u_cmp (
      .a_val (ch_val[l-1]),
      .a_idx (ch_idx[l-1]),
      .b_val (in_data[l]),
      .b_idx (base_idx + IdxW'(l)),
      .y_val (ch_val[l]),
      .y_idx (ch_idx[l])
    );
  end

  // merge beat winner with running winner; first beat ignores running state
  always_comb begin
    win_val = ch_val[NumLanes-1];
    win_idx = ch_idx[NumLanes-1];
    if (beat_cnt != '0 && !($signed(ch_val[NumLanes-1]) > $signed(run_max))) begin
      win_val = run_max;
      win_idx = run_idx;
    end
  end

  if (Depth > 1) begin : g_cnt
    // beat counter: wraps after the last beat, in_done aborts a partial vector
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)        beat_cnt <= '0;
      else if (in_valid) beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      else if (in_done)  beat_cnt <= '0;
    end
  end else begin : g_nocnt
    assign beat_cnt = '0;
  end

  // running winner, output register and sticky overflow
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      run_max      <= '0;
      run_idx      <= '0;
      out_valid    <= 1'b0;
      out_class    <= '0;
      out_max      <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        run_max <= win_val;
        run_idx <= win_idx;
      end else if (in_done) begin
        run_max <= '0;
        run_idx <= '0;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_class <= win_idx;
        out_max   <= win_val;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && last && out_valid && !out_ready) out_overflow <= 1'b1;
    end
  end
endmodule
